clock_mux_switch_sequencer: RTL and testbench
=============================================

Name: clock_mux_switch_sequencer

Overview:
- Sequences the two-input glitch-free clock mux (enable/ack pair per source) from an always-running reference clock.
- Accepts a source-select request, drops the current source's enable, and waits for its ack to fall. It then raises the new source's enable and waits for its ack to rise.
- Each wait has a timeout. Status is reported to the clock-control register block.
- Sits between the clock CSRs and the mux hard macro.

Parameters:
- DEFAULT_SEL, 0, source enabled automatically after reset (0 or 1)
- SYNC_STAGES, 2, flop stages on each incoming async ack (>=2)
- TIMEOUT_CYCLES, 1024, max reference cycles to wait for an ack transition (>=4)

Ports:
- clock  input  1  always-on reference clock
- async_reset  input  1  asynchronous active-high reset
- req_valid  input  1  switch request
- req_sel  input  1  requested source (0/1)
- req_ready  output  1  high only in IDLE or ERROR; request accepted when req_valid & req_ready
- done  output  1  one-cycle pulse on successful completion (boot or switch)
- busy  output  1  high in any sequencing state
- cur_valid  output  1  a source is confirmed active
- cur_sel  output  1  confirmed active source; meaningful only when cur_valid
- timeout_err  output  1  sticky timeout flag
- err_clear  input  1  clears timeout_err; no effect on FSM
- async_enable0  output  1  enable to mux source 0 (registered)
- async_enable1  output  1  enable to mux source 1 (registered)
- async_enable0_ack  input  1  async ack from mux, source 0
- async_enable1_ack  input  1  async ack from mux, source 1

Behaviour:
- Reset values:
  - async_enable0/1=0, req_ready=0, done=0, busy=1, cur_valid=0, cur_sel=DEFAULT_SEL, timeout_err=0
  - state=BOOT, timer=0, synchronizers=0
- Acks pass through SYNC_STAGES flops. Detection latency is SYNC_STAGES cycles after the ack edge.
- Timer width is $clog2(TIMEOUT_CYCLES+1). It clears on every state entry, increments in wait states, and saturates.
- Timeout fires when timer==TIMEOUT_CYCLES-1 and the awaited condition is still false.
- States:
  - BOOT: tgt=DEFAULT_SEL, raise enable[tgt] -> WAIT_ON.
  - IDLE: req_ready=1.
    - Accept with req_sel==cur_sel: pulse done next cycle, no enable change, stay IDLE.
    - Accept with a different req_sel: tgt=req_sel, drop enable[cur_sel] -> WAIT_OFF.
  - WAIT_OFF: wait for sync ack[cur_sel]==0.
    - On success: cur_valid=0, raise enable[tgt] -> WAIT_ON.
    - On timeout: set timeout_err, both enables 0 -> ERROR.
  - WAIT_ON: wait for sync ack[tgt]==1.
    - On success: cur_sel=tgt, cur_valid=1, pulse done -> IDLE.
    - On timeout: set timeout_err, drop enable[tgt] -> ERROR.
  - ERROR: cur_valid=0, both enables 0, req_ready=1. Accept with any req_sel: tgt=req_sel, raise enable[tgt] -> WAIT_ON, with no WAIT_OFF step.
- Invariants:
  - async_enable0 & async_enable1 is never 1.
  - No enable rises while the other source's synced ack is 1.
  - Before raising in WAIT_ON from ERROR, wait until both synced acks are 0. This wait also uses the timer and goes to ERROR on timeout.
- Requests while busy are ignored: req_ready=0 and nothing is latched.
- err_clear and a new timeout in the same cycle: set wins.
- done is asserted only for one cycle, and never in the same cycle as timeout_err rising.
- Reset mid-sequence: enables drop immediately (async), FSM restarts at BOOT.
- Latency of a successful switch = 1 + (ack-off delay + SYNC_STAGES) + 1 + (ack-on delay + SYNC_STAGES) + 1 cycles.

Decomposition:
- Package clock_mux_seq_pkg holds:
  - the state enum (BOOT, IDLE, WAIT_OFF, WAIT_ON, ERROR)
  - the default parameter constants
  - a function returning the timer width
- One sub-module, clock_ack_synchronizer: a SYNC_STAGES-deep flop chain with async reset to 0. It is instantiated twice, once per ack.
- The FSM, timer and enable registers stay in the top module.

Test Plan:
- Boot: DEFAULT_SEL=0, mux model acks after 3 cycles -> async_enable0=1 one cycle after reset release; done pulse and cur_valid=1, cur_sel=0 at ack+SYNC_STAGES+1; req_ready=1 thereafter.
- Switch 0->1: req_sel=1 in IDLE -> enable0 falls next cycle. enable1 rises only after synced ack0=0 and is never high together with enable0. Ends with done pulse, cur_sel=1.
- Same-source request: cur_sel=1, req_sel=1 -> done pulse the next cycle, enables unchanged, busy stays 0.
- Off timeout: ack1 held high forever during a 1->0 switch, TIMEOUT_CYCLES=16 -> after 16 WAIT_OFF cycles timeout_err=1, state ERROR, both enables 0, cur_valid=0. err_clear clears the flag. A retry req_sel=0 succeeds once ack1 is released.
- Request while busy: req_valid pulsed during WAIT_ON -> ignored, req_ready=0, no second done.
- Reset mid-switch: async_reset asserted in WAIT_OFF -> enables 0 in the same cycle, cur_valid=0. After release, BOOT re-enables DEFAULT_SEL.

Source files
------------

// File: rtl/clock_mux_seq_pkg.sv
// -----------------------------------------------------------------------------
// clock_mux_seq_pkg
//   Shared definitions for the clock mux switch sequencer:
//     - seq_state_e   : sequencer FSM states
//     - *_DEF         : default parameter values used by the top module
//     - timer_width() : width of the ack-wait timer for a given timeout
//     - sel_onehot()  : enable vector with only the selected source raised
// -----------------------------------------------------------------------------
package clock_mux_seq_pkg;

  typedef enum logic [2:0] {
    BOOT,
    IDLE,
    WAIT_OFF,
    WAIT_ON,
    ERROR
  } seq_state_e;

  localparam int unsigned DEFAULT_SEL_DEF    = 0;
  localparam int unsigned SYNC_STAGES_DEF    = 2;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

  // The timer must be able to hold TIMEOUT_CYCLES itself (saturation value).
  function automatic int unsigned timer_width(input int unsigned timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

  function automatic logic [1:0] sel_onehot(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/clock_ack_synchronizer.sv
// -----------------------------------------------------------------------------
// clock_ack_synchronizer
//   SYNC_STAGES-deep flop chain bringing one asynchronous mux ack into the
//   reference clock domain. All stages reset to 0.
//   Ports:
//     clock       in   reference clock
//     async_reset in   asynchronous active-high reset
//     async_in    in   asynchronous ack from the mux macro
//     sync_out    out  synchronized ack (last stage)
// -----------------------------------------------------------------------------
module clock_ack_synchronizer #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic async_reset,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
  end

  // NOTE: registers use non-blocking assignments so every stage samples the
  // value its predecessor held before the edge; blocking would collapse the chain.
  always_ff @(posedge clock or posedge async_reset) begin
    if (async_reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/clock_mux_switch_sequencer.sv
// -----------------------------------------------------------------------------
// clock_mux_switch_sequencer
//   Drives the enable/ack handshake of a two-input glitch-free clock mux from
//   an always-running reference clock. A switch drops the active source's
//   enable, waits for its ack to fall, raises the new source's enable and waits
//   for its ack to rise. Every wait is bounded by TIMEOUT_CYCLES; a timeout
//   parks the sequencer in ERROR with both enables low.
//   Ports:
//     clock, async_reset          reference clock, async active-high reset
//     req_valid/req_sel/req_ready switch request handshake (IDLE or ERROR only)
//     done                        one-cycle pulse on successful completion
//     busy                        sequencing in progress
//     cur_valid/cur_sel           confirmed active source
//     timeout_err/err_clear       sticky timeout flag and its clear
//     async_enable0/1             registered enables to the mux
//     async_enable0/1_ack         asynchronous acks from the mux
// -----------------------------------------------------------------------------
module clock_mux_switch_sequencer
  import clock_mux_seq_pkg::*;
#(
  parameter int unsigned DEFAULT_SEL    = DEFAULT_SEL_DEF,
  parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clock,
  input  logic async_reset,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  output logic done,
  output logic busy,
  output logic cur_valid,
  output logic cur_sel,
  output logic timeout_err,
  input  logic err_clear,
  output logic async_enable0,
  output logic async_enable1,
  input  logic async_enable0_ack,
  input  logic async_enable1_ack
);

  localparam logic            DEF_SEL    = (DEFAULT_SEL != 0);
  localparam int unsigned     TW         = timer_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]   TIMER_SAT  = TW'(TIMEOUT_CYCLES);

  seq_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    en_q, en_d;
  logic          tgt_q, tgt_d;
  logic          cur_sel_q, cur_sel_d;
  logic          cur_valid_q, cur_valid_d;
  logic          done_q, done_d;
  logic          timeout_err_q, timeout_err_d;
  // Set when WAIT_ON is entered from ERROR: both acks must read low before
  // the target enable may rise.
  logic          raise_pending_q, raise_pending_d;

  logic [1:0]    ack_sync;
  logic          timer_expired;
  logic [TW-1:0] timer_next;
  logic          timeout_set;

  clock_ack_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_ack0_sync (
    .clock       (clock),
    .async_reset (async_reset),
    .async_in    (async_enable0_ack),
    .sync_out    (ack_sync[0])
  );

  clock_ack_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_ack1_sync (
    .clock       (clock),
    .async_reset (async_reset),
    .async_in    (async_enable1_ack),
    .sync_out    (ack_sync[1])
  );

  assign timer_expired = (timer_q == TIMER_LAST);
  assign timer_next    = (timer_q == TIMER_SAT) ? timer_q : timer_q + 1'b1;

  // NOTE: every variable written here gets its default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    en_d            = en_q;
    tgt_d           = tgt_q;
    cur_sel_d       = cur_sel_q;
    cur_valid_d     = cur_valid_q;
    raise_pending_d = raise_pending_q;
    done_d          = 1'b0;
    timeout_set     = 1'b0;

    unique case (state_q)
      BOOT: begin
        // Synchronizers are still clear here, so the raise is always safe.
        tgt_d           = DEF_SEL;
        en_d            = sel_onehot(DEF_SEL);
        raise_pending_d = 1'b0;
        timer_d         = '0;
        state_d         = WAIT_ON;
      end

      IDLE: begin
        if (req_valid) begin
          if (req_sel == cur_sel_q) begin
            done_d = 1'b1;
          end else begin
            tgt_d            = req_sel;
            en_d[cur_sel_q]  = 1'b0;
            timer_d          = '0;
            state_d          = WAIT_OFF;
          end
        end
      end

      WAIT_OFF: begin
        if (!ack_sync[cur_sel_q]) begin
          // Old source confirmed off, which is the only ack that could block
          // the raise of the target.
          cur_valid_d     = 1'b0;
          en_d            = sel_onehot(tgt_q);
          raise_pending_d = 1'b0;
          timer_d         = '0;
          state_d         = WAIT_ON;
        end else if (timer_expired) begin
          timeout_set = 1'b1;
          en_d        = 2'b00;
          cur_valid_d = 1'b0;
          timer_d     = '0;
          state_d     = ERROR;
        end else begin
          timer_d = timer_next;
        end
      end

      WAIT_ON: begin
        if (raise_pending_q) begin
          if (ack_sync == 2'b00) begin
            // The ack-rise wait starts fresh once the enable actually goes up.
            en_d            = sel_onehot(tgt_q);
            raise_pending_d = 1'b0;
            timer_d         = '0;
          end else if (timer_expired) begin
            timeout_set     = 1'b1;
            en_d            = 2'b00;
            raise_pending_d = 1'b0;
            timer_d         = '0;
            state_d         = ERROR;
          end else begin
            timer_d = timer_next;
          end
        end else if (ack_sync[tgt_q]) begin
          cur_sel_d   = tgt_q;
          cur_valid_d = 1'b1;
          done_d      = 1'b1;
          timer_d     = '0;
          state_d     = IDLE;
        end else if (timer_expired) begin
          timeout_set = 1'b1;
          en_d        = 2'b00;
          cur_valid_d = 1'b0;
          timer_d     = '0;
          state_d     = ERROR;
        end else begin
          timer_d = timer_next;
        end
      end

      ERROR: begin
        cur_valid_d = 1'b0;
        en_d        = 2'b00;
        if (req_valid) begin
          tgt_d           = req_sel;
          raise_pending_d = 1'b1;
          timer_d         = '0;
          state_d         = WAIT_ON;
        end
      end

      default: begin
        en_d    = 2'b00;
        timer_d = '0;
        state_d = BOOT;
      end
    endcase

    // A timeout in the same cycle as err_clear leaves the flag set.
    timeout_err_d = (timeout_err_q & ~err_clear) | timeout_set;
  end

  always_ff @(posedge clock or posedge async_reset) begin
    if (async_reset) begin
      state_q         <= BOOT;
      timer_q         <= '0;
      en_q            <= 2'b00;
      tgt_q           <= DEF_SEL;
      cur_sel_q       <= DEF_SEL;
      cur_valid_q     <= 1'b0;
      done_q          <= 1'b0;
      timeout_err_q   <= 1'b0;
      raise_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      en_q            <= en_d;
      tgt_q           <= tgt_d;
      cur_sel_q       <= cur_sel_d;
      cur_valid_q     <= cur_valid_d;
      done_q          <= done_d;
      timeout_err_q   <= timeout_err_d;
      raise_pending_q <= raise_pending_d;
    end
  end

  assign async_enable0 = en_q[0];
  assign async_enable1 = en_q[1];
  assign req_ready     = (state_q == IDLE) || (state_q == ERROR);
  assign busy          = (state_q == BOOT) || (state_q == WAIT_OFF) || (state_q == WAIT_ON);
  assign done          = done_q;
  assign cur_valid     = cur_valid_q;
  assign cur_sel       = cur_sel_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_clock_mux_switch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_clock_mux_switch_sequencer
//   Bench for clock_mux_switch_sequencer with a behavioural mux model (acks
//   follow enables after a random delay, optionally stuck) and a reference
//   model that tracks what the sequencer is waiting for and its deadline.
//   Outputs are compared with the model on every falling clock edge.
// -----------------------------------------------------------------------------
module tb_clock_mux_switch_sequencer;

  localparam int  SYNC    = 2;
  localparam int  TMO     = 16;
  localparam logic DEF    = 1'b0;

  logic clock       = 1'b0;
  logic async_reset = 1'b1;
  logic req_valid   = 1'b0;
  logic req_sel     = 1'b0;
  logic err_clear   = 1'b0;
  logic [1:0] mux_ack = 2'b00;

  logic req_ready, done, busy, cur_valid, cur_sel, timeout_err;
  logic en0, en1;
  logic [1:0] en_v;
  assign en_v = {en1, en0};

  always #5 clock = ~clock;

  clock_mux_switch_sequencer #(
    .DEFAULT_SEL    (0),
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock             (clock),
    .async_reset       (async_reset),
    .req_valid         (req_valid),
    .req_sel           (req_sel),
    .req_ready         (req_ready),
    .done              (done),
    .busy              (busy),
    .cur_valid         (cur_valid),
    .cur_sel           (cur_sel),
    .timeout_err       (timeout_err),
    .err_clear         (err_clear),
    .async_enable0     (en0),
    .async_enable1     (en1),
    .async_enable0_ack (mux_ack[0]),
    .async_enable1_ack (mux_ack[1])
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic act, input logic exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: dut=%b expected=%b at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Mux macro model: each ack follows its enable after a delay of 1..6 falling
  // edges (or fix_delay when non-zero). stuck: 0 normal, 1 held high, 2 held low.
  // ---------------------------------------------------------------------------
  int stuck[2]  = '{0, 0};
  int d_cnt[2]  = '{0, 0};
  int d_len[2]  = '{1, 1};
  int fix_delay = 0;

  initial forever begin
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      if (stuck[i] == 1) begin
        mux_ack[i] = 1'b1;
      end else if (stuck[i] == 2) begin
        mux_ack[i] = 1'b0;
      end else if (mux_ack[i] != en_v[i]) begin
        if (d_cnt[i] == 0) d_len[i] = (fix_delay != 0) ? fix_delay : int'($urandom_range(1, 6));
        d_cnt[i]++;
        if (d_cnt[i] >= d_len[i]) begin
          mux_ack[i] = en_v[i];
          d_cnt[i]   = 0;
        end
      end else begin
        d_cnt[i] = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model. It records what the sequencer is waiting for and the
  // absolute cycle at which that wait gives up; the sequencer's view of an ack
  // is the raw ack as sampled SYNC rising edges earlier.
  // ---------------------------------------------------------------------------
  typedef enum {AWAIT_NOTHING, AWAIT_OLD_LOW, AWAIT_BOTH_LOW, AWAIT_NEW_HIGH} await_e;

  await_e     m_wait        = AWAIT_NOTHING;
  logic       m_boot        = 1'b1;
  logic       m_tgt         = DEF;
  int         m_cyc         = 0;
  int         m_deadline    = 0;
  logic       m_timeout;
  logic [1:0] m_sa;
  logic [1:0] hist[$];
  logic [1:0] exp_en        = 2'b00;
  logic       exp_done      = 1'b0;
  logic       exp_cur_valid = 1'b0;
  logic       exp_cur_sel   = DEF;
  logic       exp_err       = 1'b0;

  initial forever begin
    @(posedge clock or posedge async_reset);
    if (async_reset) begin
      m_boot        = 1'b1;
      m_wait        = AWAIT_NOTHING;
      m_tgt         = DEF;
      m_cyc         = 0;
      m_deadline    = 0;
      exp_en        = 2'b00;
      exp_done      = 1'b0;
      exp_cur_valid = 1'b0;
      exp_cur_sel   = DEF;
      exp_err       = 1'b0;
      hist.delete();
      for (int k = 0; k < SYNC; k++) hist.push_back(2'b00);
    end else begin
      m_cyc++;
      m_sa      = hist[SYNC-1];
      exp_done  = 1'b0;
      m_timeout = 1'b0;
      if (m_boot) begin
        m_boot     = 1'b0;
        m_tgt      = DEF;
        exp_en     = 2'b01 << DEF;
        m_wait     = AWAIT_NEW_HIGH;
        m_deadline = m_cyc + TMO;
      end else begin
        case (m_wait)
          AWAIT_NOTHING: begin
            if (req_valid) begin
              if (exp_cur_valid && req_sel == exp_cur_sel) begin
                exp_done = 1'b1;
              end else if (exp_cur_valid) begin
                m_tgt      = req_sel;
                exp_en     = 2'b00;
                m_wait     = AWAIT_OLD_LOW;
                m_deadline = m_cyc + TMO;
              end else begin
                m_tgt      = req_sel;
                m_wait     = AWAIT_BOTH_LOW;
                m_deadline = m_cyc + TMO;
              end
            end
          end
          AWAIT_OLD_LOW: begin
            if (!m_sa[exp_cur_sel]) begin
              exp_cur_valid = 1'b0;
              exp_en        = 2'b01 << m_tgt;
              m_wait        = AWAIT_NEW_HIGH;
              m_deadline    = m_cyc + TMO;
            end else if (m_cyc == m_deadline) begin
              m_timeout = 1'b1;
            end
          end
          AWAIT_BOTH_LOW: begin
            if (m_sa == 2'b00) begin
              exp_en     = 2'b01 << m_tgt;
              m_wait     = AWAIT_NEW_HIGH;
              m_deadline = m_cyc + TMO;
            end else if (m_cyc == m_deadline) begin
              m_timeout = 1'b1;
            end
          end
          default: begin
            if (m_sa[m_tgt]) begin
              exp_cur_sel   = m_tgt;
              exp_cur_valid = 1'b1;
              exp_done      = 1'b1;
              m_wait        = AWAIT_NOTHING;
            end else if (m_cyc == m_deadline) begin
              m_timeout = 1'b1;
            end
          end
        endcase
        if (m_timeout) begin
          exp_en        = 2'b00;
          exp_cur_valid = 1'b0;
          m_wait        = AWAIT_NOTHING;
        end
      end
      exp_err = (exp_err & ~err_clear) | m_timeout;
      hist.push_front(mux_ack);
      void'(hist.pop_back());
    end
  end

  // Per-cycle comparison of every output against the model.
  logic exp_ready;
  initial forever begin
    @(negedge clock);
    exp_ready = (m_wait == AWAIT_NOTHING) && !m_boot;
    check("req_ready", req_ready, exp_ready);
    check("busy", busy, !exp_ready);
    check("done", done, exp_done);
    check("cur_valid", cur_valid, exp_cur_valid);
    check("timeout_err", timeout_err, exp_err);
    check("async_enable0", en0, exp_en[0]);
    check("async_enable1", en1, exp_en[1]);
    check("enables_exclusive", en0 & en1, 1'b0);
    if (exp_cur_valid) check("cur_sel", cur_sel, exp_cur_sel);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. The main thread always sits just after a falling edge.
  // ---------------------------------------------------------------------------
  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic request(input logic s);
    req_valid = 1'b1;
    req_sel   = s;
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic pin(input string name, input logic dut_v, input logic mod_v, input logic lit);
    check({name, "_dut"}, dut_v, lit);
    check({name, "_model"}, mod_v, lit);
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!done && k < 80) begin
      cyc();
      k++;
    end
    check({name, "_done_seen"}, done, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int dn;
  int stuck_left[2] = '{0, 0};

  initial begin
    // Reset state.
    fix_delay = 3;
    cyc(2);
    check("rst_busy", busy, 1'b1);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_en0", en0, 1'b0);
    check("rst_en1", en1, 1'b0);
    check("rst_cur_valid", cur_valid, 1'b0);
    check("rst_cur_sel", cur_sel, DEF);
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_done", done, 1'b0);

    // Boot with a 3-cycle ack: enable after 1 edge, done after 6.
    async_reset = 1'b0;
    cyc(1);
    pin("boot_en0", en0, exp_en[0], 1'b1);
    pin("boot_busy", busy, !((m_wait == AWAIT_NOTHING) && !m_boot), 1'b1);
    cyc(4);
    pin("boot_done_early", done, exp_done, 1'b0);
    cyc(1);
    pin("boot_done", done, exp_done, 1'b1);
    pin("boot_cur_valid", cur_valid, exp_cur_valid, 1'b1);
    pin("boot_cur_sel", cur_sel, exp_cur_sel, 1'b0);
    check("boot_req_ready", req_ready, 1'b1);
    cyc(1);
    pin("boot_done_pulse_end", done, exp_done, 1'b0);
    fix_delay = 0;

    // Switch 0 -> 1.
    request(1'b1);
    pin("sw01_en0_drop", en0, exp_en[0], 1'b0);
    wait_done("sw01");
    pin("sw01_cur_sel", cur_sel, exp_cur_sel, 1'b1);
    pin("sw01_en1", en1, exp_en[1], 1'b1);

    // Same-source request.
    cyc(1);
    request(1'b1);
    pin("same_done", done, exp_done, 1'b1);
    pin("same_busy", busy, !((m_wait == AWAIT_NOTHING) && !m_boot), 1'b0);
    pin("same_en1", en1, exp_en[1], 1'b1);
    cyc(1);
    pin("same_done_end", done, exp_done, 1'b0);

    // Off timeout: ack1 held high during a 1 -> 0 switch.
    stuck[1] = 1;
    request(1'b0);
    pin("tmo_en1_drop", en1, exp_en[1], 1'b0);
    cyc(15);
    pin("tmo_err_before", timeout_err, exp_err, 1'b0);
    cyc(1);
    pin("tmo_err", timeout_err, exp_err, 1'b1);
    pin("tmo_cur_valid", cur_valid, exp_cur_valid, 1'b0);
    pin("tmo_en0", en0, exp_en[0], 1'b0);
    pin("tmo_en1", en1, exp_en[1], 1'b0);
    check("tmo_req_ready", req_ready, 1'b1);
    err_clear = 1'b1;
    cyc(1);
    err_clear = 1'b0;
    pin("tmo_err_cleared", timeout_err, exp_err, 1'b0);
    stuck[1] = 0;
    request(1'b0);
    wait_done("retry");
    pin("retry_cur_sel", cur_sel, exp_cur_sel, 1'b0);
    pin("retry_en0", en0, exp_en[0], 1'b1);

    // Request while busy in WAIT_ON is ignored.
    cyc(1);
    request(1'b1);
    dn = 0;
    while (!en1 && dn < 40) begin
      cyc();
      dn++;
    end
    check("busy_reached_wait_on", en1, 1'b1);
    check("busy_req_ready", req_ready, 1'b0);
    req_valid = 1'b1;
    req_sel   = 1'b0;
    cyc(1);
    req_valid = 1'b0;
    wait_done("busy");
    check("busy_cur_sel", cur_sel, 1'b1);
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (done) dn++;
    end
    check_int("busy_no_second_done", dn, 0);

    // Reset mid-switch while in WAIT_OFF.
    request(1'b0);
    cyc(1);
    check("rstmid_pre_cur_valid", cur_valid, 1'b1);
    #2 async_reset = 1'b1;
    #1;
    check("rstmid_en0", en0, 1'b0);
    check("rstmid_en1", en1, 1'b0);
    check("rstmid_cur_valid", cur_valid, 1'b0);
    check("rstmid_busy", busy, 1'b1);
    cyc(2);
    async_reset = 1'b0;
    cyc(1);
    pin("rstmid_boot_en0", en0, exp_en[0], 1'b1);
    wait_done("rstmid_boot");
    check("rstmid_cur_sel", cur_sel, DEF);

    // Randomized traffic: requests at any time, clears, stuck acks, resets.
    for (int n = 0; n < 1500; n++) begin
      req_valid = ($urandom_range(0, 7) == 0);
      req_sel   = 1'($urandom_range(0, 1));
      err_clear = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < 2; i++) begin
        if (stuck_left[i] > 0) begin
          stuck_left[i]--;
          if (stuck_left[i] == 0) stuck[i] = 0;
        end else if ($urandom_range(0, 199) == 0) begin
          stuck[i]      = int'($urandom_range(1, 2));
          stuck_left[i] = int'($urandom_range(10, 40));
        end
      end
      if ($urandom_range(0, 599) == 0) begin
        #2 async_reset = 1'b1;
        cyc(2);
        async_reset = 1'b0;
      end
      cyc();
    end

    req_valid = 1'b0;
    err_clear = 1'b0;
    stuck     = '{0, 0};
    cyc(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
